// File: rtl/buscador_vizinhos_pkg.sv
// Shared types and width helpers for the neighbour fetcher and the relations loader.
package buscador_vizinhos_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeRel,
    StAvaliaRel,
    StAvaliaObs,
    StEntrega,
    StFim
  } estado_e;

  function automatic int unsigned viz_width(int unsigned max_vizinhos);
    return $clog2(max_vizinhos);
  endfunction

  // Relations memory is addressed as {node, slot}.
  function automatic int unsigned rel_addr_width(int unsigned addr_width,
                                                 int unsigned max_vizinhos);
    return addr_width + $clog2(max_vizinhos);
  endfunction

  // Relations word carries a slot-valid bit above the neighbour address.
  function automatic int unsigned relacoes_data_width(int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/buscador_vizinhos_if.sv
// Request, memory read ports and neighbour stream of the neighbour fetcher.
interface buscador_vizinhos_if #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned MAX_VIZINHOS = 8
) ();
  import buscador_vizinhos_pkg::*;

  localparam int unsigned REL_ADDR_WIDTH      = rel_addr_width(ADDR_WIDTH, MAX_VIZINHOS);
  localparam int unsigned RELACOES_DATA_WIDTH = relacoes_data_width(ADDR_WIDTH);

  logic                           start_in;
  logic [ADDR_WIDTH-1:0]          no_in;
  logic                           busy_out;
  logic                           done_out;
  logic                           relacoes_rd_enable_out;
  logic [REL_ADDR_WIDTH-1:0]      relacoes_rd_addr_out;
  logic [RELACOES_DATA_WIDTH-1:0] relacoes_rd_data_in;
  logic                           obstaculos_rd_enable_out;
  logic [ADDR_WIDTH-1:0]          obstaculos_rd_addr_out;
  logic                           obstaculos_rd_data_in;
  logic                           vizinho_valid_out;
  logic [ADDR_WIDTH-1:0]          vizinho_addr_out;
  logic                           vizinho_ready_in;

  modport master (
    input  start_in, no_in, relacoes_rd_data_in, obstaculos_rd_data_in, vizinho_ready_in,
    output busy_out, done_out, relacoes_rd_enable_out, relacoes_rd_addr_out,
           obstaculos_rd_enable_out, obstaculos_rd_addr_out, vizinho_valid_out,
           vizinho_addr_out
  );

  modport slave (
    output start_in, no_in, relacoes_rd_data_in, obstaculos_rd_data_in, vizinho_ready_in,
    input  busy_out, done_out, relacoes_rd_enable_out, relacoes_rd_addr_out,
           obstaculos_rd_enable_out, obstaculos_rd_addr_out, vizinho_valid_out,
           vizinho_addr_out
  );

endinterface

// File: rtl/buscador_vizinhos.sv
// Walks the relation slots of one node, drops obstacle neighbours and streams the free ones
// out over a valid/ready handshake. MAX_VIZINHOS must be a power of two, at least 2.
module buscador_vizinhos
  import buscador_vizinhos_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned MAX_VIZINHOS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  buscador_vizinhos_if.master    bus_io
);

  localparam int unsigned VIZ_WIDTH = viz_width(MAX_VIZINHOS);
  localparam logic [VIZ_WIDTH-1:0] KUltimo = VIZ_WIDTH'(MAX_VIZINHOS - 1);

  estado_e               estado_q;
  logic [VIZ_WIDTH-1:0]  k_q;
  logic [ADDR_WIDTH-1:0] no_q;
  logic [ADDR_WIDTH-1:0] viz_q;

  logic                  rel_valido;
  logic [ADDR_WIDTH-1:0] rel_viz;
  logic                  ultimo;
  estado_e               estado_prox;
  logic [VIZ_WIDTH-1:0]  k_prox;

  assign rel_valido = bus_io.relacoes_rd_data_in[ADDR_WIDTH];
  assign rel_viz    = bus_io.relacoes_rd_data_in[ADDR_WIDTH-1:0];

  // After a skip or a transfer: stop at the last slot, k never wraps.
  assign ultimo      = (k_q == KUltimo);
  assign estado_prox = ultimo ? StFim : StLeRel;
  assign k_prox      = ultimo ? k_q : k_q + VIZ_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= StIdle;
      k_q      <= '0;
      no_q     <= '0;
      viz_q    <= '0;
    end else begin
      unique case (estado_q)
        StIdle: begin
          if (bus_io.start_in) begin
            no_q     <= bus_io.no_in;
            k_q      <= '0;
            estado_q <= StLeRel;
          end
        end
        StLeRel: estado_q <= StAvaliaRel;
        StAvaliaRel: begin
          if (rel_valido) begin
            viz_q    <= rel_viz;
            estado_q <= StAvaliaObs;
          end else begin
            estado_q <= StFim;
          end
        end
        StAvaliaObs: begin
          if (bus_io.obstaculos_rd_data_in) begin
            k_q      <= k_prox;
            estado_q <= estado_prox;
          end else begin
            estado_q <= StEntrega;
          end
        end
        StEntrega: begin
          if (bus_io.vizinho_ready_in) begin
            k_q      <= k_prox;
            estado_q <= estado_prox;
          end
        end
        StFim:   estado_q <= StIdle;
        default: estado_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy_out               = (estado_q != StIdle);
  assign bus_io.done_out               = (estado_q == StFim);
  assign bus_io.relacoes_rd_enable_out = (estado_q == StLeRel);
  assign bus_io.relacoes_rd_addr_out   = {no_q, k_q};
  // Obstacle lookup is issued from the relations word itself to keep the 1-cycle turnaround.
  assign bus_io.obstaculos_rd_enable_out = (estado_q == StAvaliaRel) && rel_valido;
  assign bus_io.obstaculos_rd_addr_out   = (estado_q == StAvaliaRel) ? rel_viz : viz_q;
  assign bus_io.vizinho_valid_out        = (estado_q == StEntrega);
  assign bus_io.vizinho_addr_out         = viz_q;

endmodule

// File: tb/tb_buscador_vizinhos.sv
// Bench for buscador_vizinhos: behavioural memories plus a slot-walk reference model.
module tb_buscador_vizinhos;

  localparam int unsigned AW = 8;
  localparam int unsigned MV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buscador_vizinhos_if #(.ADDR_WIDTH(AW), .MAX_VIZINHOS(MV)) bus ();

  buscador_vizinhos #(.ADDR_WIDTH(AW), .MAX_VIZINHOS(MV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  logic [AW:0] rel_mem [0:2047];
  logic        obs_mem [0:255];

  int cyc;
  int rel_log[$], rel_cyc[$], obs_log[$], obs_cyc[$], val_cyc[$], xfer_log[$], done_cyc[$];
  int exp_rel[$], exp_obs[$], exp_xfer[$];
  int n_checks = 0;
  int n_errors = 0;

  // 1-cycle-latency memories and an event log of everything the DUT does.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.relacoes_rd_enable_out) begin
      bus.relacoes_rd_data_in <= rel_mem[bus.relacoes_rd_addr_out];
      rel_log.push_back(int'(bus.relacoes_rd_addr_out));
      rel_cyc.push_back(cyc);
    end
    if (bus.obstaculos_rd_enable_out) begin
      bus.obstaculos_rd_data_in <= obs_mem[bus.obstaculos_rd_addr_out];
      obs_log.push_back(int'(bus.obstaculos_rd_addr_out));
      obs_cyc.push_back(cyc);
    end
    if (bus.vizinho_valid_out) begin
      val_cyc.push_back(cyc);
      if (bus.vizinho_ready_in) xfer_log.push_back(int'(bus.vizinho_addr_out));
    end
    if (bus.done_out) done_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_rel(input int node, input int k, input bit valid, input int addr);
    rel_mem[node * MV + k] = {valid, 8'(addr)};
  endtask

  task automatic setup_random(input int node, input int n_valid, input int obs_pct);
    for (int k = 0; k < int'(MV); k++) begin
      int a;
      bit v;
      a = $urandom_range(0, 255);
      if (k < n_valid) v = 1'b1;
      else if (k == n_valid) v = 1'b0;
      else v = 1'($urandom_range(0, 1));
      set_rel(node, k, v, a);
      obs_mem[a] = ($urandom_range(0, 99) < obs_pct);
    end
  endtask

  // Reference: read slots in order until one is invalid or all are read; free ones go out.
  task automatic build_model(input int node);
    exp_rel.delete();
    exp_obs.delete();
    exp_xfer.delete();
    for (int k = 0; k < int'(MV); k++) begin
      logic [AW:0] w;
      exp_rel.push_back(node * MV + k);
      w = rel_mem[node * MV + k];
      if (!w[AW]) break;
      exp_obs.push_back(int'(w[AW-1:0]));
      if (!obs_mem[w[AW-1:0]]) exp_xfer.push_back(int'(w[AW-1:0]));
    end
  endtask

  task automatic clear_logs();
    rel_log.delete(); rel_cyc.delete(); obs_log.delete(); obs_cyc.delete();
    val_cyc.delete(); xfer_log.delete(); done_cyc.delete();
  endtask

  task automatic compare_queue(input string tag, input int got[$], input int exp[$]);
    check_eq({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check_eq(tag, got[i], exp[i]);
  endtask

  task automatic run_fetch(input int node, input int ready_pct, input int hold, input bit inject,
                           output int t_done);
    int s;
    int wait_cnt;
    bit prev_hold;
    logic [AW-1:0] prev_addr;
    build_model(node);
    clear_logs();
    @(negedge clk);
    check_eq("idle_busy", bus.busy_out, 0);
    bus.start_in = 1'b1;
    bus.no_in = AW'(node);
    bus.vizinho_ready_in = 1'b0;
    s = cyc;
    t_done = -1;
    wait_cnt = 0;
    prev_hold = 1'b0;
    prev_addr = '0;
    for (int c = 1; c <= 200 && t_done < 0; c++) begin
      @(negedge clk);
      bus.start_in = inject && (c == 2);
      if (inject && c == 2) bus.no_in = AW'(9);
      check_eq("busy", bus.busy_out, 1);
      if (prev_hold) begin
        check_eq("hold_valid", bus.vizinho_valid_out, 1);
        check_eq("hold_addr", bus.vizinho_addr_out, prev_addr);
      end
      if (bus.vizinho_valid_out)
        check_eq("quiet_mem", {bus.relacoes_rd_enable_out, bus.obstaculos_rd_enable_out}, 0);
      if (hold > 0) begin
        if (bus.vizinho_valid_out) begin
          bus.vizinho_ready_in = (wait_cnt >= hold);
          wait_cnt = bus.vizinho_ready_in ? 0 : wait_cnt + 1;
        end else begin
          bus.vizinho_ready_in = 1'b0;
        end
      end else begin
        bus.vizinho_ready_in = ($urandom_range(0, 99) < ready_pct);
      end
      prev_hold = bus.vizinho_valid_out && !bus.vizinho_ready_in;
      prev_addr = bus.vizinho_addr_out;
      if (bus.done_out) t_done = c;
    end
    if (t_done < 0) check_eq("done_timeout", 0, 1);
    @(negedge clk);
    bus.start_in = 1'b0;
    bus.vizinho_ready_in = 1'b0;
    check_eq("post_busy", bus.busy_out, 0);
    check_eq("post_done", bus.done_out, 0);
    compare_queue("rel_reads", rel_log, exp_rel);
    compare_queue("obs_reads", obs_log, exp_obs);
    compare_queue("transfers", xfer_log, exp_xfer);
    check_eq("done_pulses", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check_eq("done_cycle", done_cyc[0] - s, t_done);
    if (rel_cyc.size() > 0) check_eq("rel_latency", rel_cyc[0] - s, 1);
    if (exp_obs.size() > 0 && obs_cyc.size() > 0) check_eq("obs_latency", obs_cyc[0] - s, 2);
    if (exp_obs.size() == 0) check_eq("empty_done_cycle", t_done, 3);
    if (exp_xfer.size() > 0 && exp_xfer[0] == exp_obs[0] && val_cyc.size() > 0)
      check_eq("valid_latency", val_cyc[0] - s, 4);
  endtask

  task automatic setup_node3();
    set_rel(3, 0, 1'b1, 4);
    set_rel(3, 1, 1'b1, 5);
    set_rel(3, 2, 1'b0, 0);
    set_rel(3, 3, 1'b1, 7);
    obs_mem[4] = 1'b0;
    obs_mem[5] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 2048; i++) rel_mem[i] = '0;
    for (int i = 0; i < 256; i++) obs_mem[i] = 1'b0;
    bus.start_in = 1'b0;
    bus.no_in = '0;
    bus.vizinho_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", bus.busy_out, 0);
    check_eq("reset_valid", bus.vizinho_valid_out, 0);
    check_eq("reset_addr", bus.vizinho_addr_out, 0);
    rst_n = 1'b1;

    // Node 3: one free neighbour, one obstacle, terminator at slot 2.
    setup_node3();
    run_fetch(3, 100, 0, 1'b0, t);
    check_eq("n3_xfer_count", xfer_log.size(), 1);
    if (xfer_log.size() > 0) check_eq("n3_xfer_addr", xfer_log[0], 4);
    check_eq("n3_rel_count", rel_log.size(), 3);

    // Node 1: full list, all free.
    for (int k = 0; k < 8; k++) begin
      set_rel(1, k, 1'b1, 10 + k);
      obs_mem[10 + k] = 1'b0;
    end
    run_fetch(1, 100, 0, 1'b0, t);
    check_eq("n1_xfer_count", xfer_log.size(), 8);
    check_eq("n1_rel_count", rel_log.size(), 8);

    // Empty list.
    set_rel(5, 0, 1'b0, 0);
    set_rel(5, 1, 1'b1, 33);
    run_fetch(5, 100, 0, 1'b0, t);
    check_eq("empty_obs_reads", obs_log.size(), 0);
    check_eq("empty_valid", val_cyc.size(), 0);
    check_eq("empty_done", t, 3);

    // Backpressure: five stalled cycles per neighbour.
    for (int k = 0; k < 3; k++) begin
      set_rel(6, k, 1'b1, 20 + k);
      obs_mem[20 + k] = 1'b0;
    end
    set_rel(6, 3, 1'b0, 0);
    run_fetch(6, 0, 5, 1'b0, t);
    check_eq("bp_valid_cycles", val_cyc.size(), 18);

    // Stray start during a fetch of node 2.
    setup_random(2, 8, 20);
    run_fetch(2, 70, 0, 1'b1, t);

    // Reset while a neighbour is being offered.
    setup_node3();
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.no_in = AW'(3);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      bus.vizinho_ready_in = 1'b0;
      if (bus.vizinho_valid_out) break;
    end
    check_eq("rst_reach_entrega", bus.vizinho_valid_out, 1);
    done_cyc.delete();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", bus.busy_out, 0);
    check_eq("rst_done", bus.done_out, 0);
    check_eq("rst_valid", bus.vizinho_valid_out, 0);
    check_eq("rst_vaddr", bus.vizinho_addr_out, 0);
    check_eq("rst_rel_en", bus.relacoes_rd_enable_out, 0);
    check_eq("rst_obs_en", bus.obstaculos_rd_enable_out, 0);
    check_eq("rst_rel_addr", bus.relacoes_rd_addr_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_busy", bus.busy_out, 0);
    check_eq("rel_done", bus.done_out, 0);
    check_eq("rst_no_done_pulse", done_cyc.size(), 0);
    run_fetch(3, 100, 0, 1'b0, t);
    check_eq("after_rst_xfer_count", xfer_log.size(), 1);
    if (xfer_log.size() > 0) check_eq("after_rst_xfer_addr", xfer_log[0], 4);

    // Randomized lists, obstacles and backpressure.
    for (int i = 0; i < 20; i++) begin
      int node;
      node = $urandom_range(0, 255);
      setup_random(node, $urandom_range(0, 8), 30);
      run_fetch(node, $urandom_range(30, 100), 0, 1'b0, t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
